// File: rtl/instr_mem_readout.sv
// Button-stepped byte readout of a captured 64-bit instruction or hazard image to an 8-bit display.
// Optional build macro READOUT_CHECKSUM_EN adds an XOR-checksum step after the last byte.
module instr_mem_readout #(
  parameter int NUM_BYTES       = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_BYTES-1:0] instrMemBits,
  input  logic [8*NUM_BYTES-1:0] hazardMemBits,
  input  logic                   sel_hazard,
  input  logic                   but_load,
  input  logic                   but_next,
  output logic [7:0]             out_val,
  output logic [2:0]             byte_idx,
  output logic                   out_valid,
  output logic                   done
);

  localparam int         W        = 8 * NUM_BYTES;
  localparam int         CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_CSUM,
    ST_DONE
  } state_t;

  // Bit 0 = but_next (every accepted change is an event), bit 1 = but_load (rising only).
  logic [1:0] btn_raw;
  logic [1:0] btn_evt;
  logic       next_evt;
  logic       load_evt;

  assign btn_raw  = {but_load, but_next};
  assign next_evt = btn_evt[0];
  assign load_evt = btn_evt[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_q;
      logic          sync2_q;
      logic          acc_q;
      logic          acc_d;
      logic          evt_q;
      logic          evt_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          acc_q   <= 1'b0;
          evt_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
          acc_q   <= acc_d;
          evt_q   <= evt_d;
          cnt_q   <= cnt_d;
        end
      end

      // A level that disagrees with the accepted one must persist unbroken to be taken.
      always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        evt_d = 1'b0;
        if (sync2_q != acc_q) begin
          if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            acc_d = sync2_q;
            evt_d = (gi == 1) ? sync2_q : 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      assign btn_evt[gi] = evt_q;
    end
  endgenerate

  state_t     state_q;
  state_t     state_d;
  logic [W-1:0] shadow_q;
  logic [W-1:0] shadow_d;
  logic [2:0] byte_idx_q;
  logic [2:0] byte_idx_d;
  logic [7:0] out_val_q;
  logic [7:0] out_val_d;
  logic       out_valid_q;
  logic       out_valid_d;
  logic       done_q;
  logic       done_d;

  logic [W-1:0] image_sel;
  logic [2:0]   idx_inc;
  logic [7:0]   shadow_byte [NUM_BYTES];

  assign image_sel = sel_hazard ? hazardMemBits : instrMemBits;
  assign idx_inc   = byte_idx_q + 3'd1;

  // Byte 0 is the most significant byte, i.e. the first one entered.
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
      assign shadow_byte[gi] = shadow_q[W-1-8*gi -: 8];
    end
  endgenerate

`ifdef READOUT_CHECKSUM_EN
  logic [7:0] checksum;

  always_comb begin
    checksum = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      checksum = checksum ^ shadow_byte[i];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      byte_idx_q  <= 3'd0;
      out_val_q   <= 8'h00;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      byte_idx_q  <= byte_idx_d;
      out_val_q   <= out_val_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Load has priority over a coincident step; the step is simply dropped.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    byte_idx_d  = byte_idx_q;
    out_val_d   = out_val_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;

    if (load_evt) begin
      shadow_d    = image_sel;
      byte_idx_d  = 3'd0;
      out_val_d   = image_sel[W-1 -: 8];
      out_valid_d = 1'b1;
      done_d      = 1'b0;
      state_d     = ST_SHOW;
    end else if (next_evt) begin
      case (state_q)
        ST_SHOW: begin
          if (byte_idx_q < LAST_IDX) begin
            byte_idx_d = idx_inc;
            out_val_d  = shadow_byte[idx_inc];
          end else begin
`ifdef READOUT_CHECKSUM_EN
            state_d   = ST_CSUM;
            out_val_d = checksum;
`else
            state_d     = ST_DONE;
            out_val_d   = 8'h00;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
`endif
          end
        end
        ST_CSUM: begin
          state_d     = ST_DONE;
          out_val_d   = 8'h00;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_val   = out_val_q;
  assign byte_idx  = byte_idx_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_instr_mem_readout.sv
// Directed bench for instr_mem_readout: stepping, debounce, shadow isolation, load priority, reset.
module tb_instr_mem_readout;

  logic        clk;
  logic        rst;
  logic [63:0] instrMemBits;
  logic [63:0] hazardMemBits;
  logic        sel_hazard;
  logic        but_load;
  logic        but_next;
  logic [7:0]  out_val;
  logic [2:0]  byte_idx;
  logic        out_valid;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp1 [8] = '{8'hCA, 8'hDC, 8'h59, 8'h9E, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp3 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

  instr_mem_readout #(.NUM_BYTES(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .instrMemBits  (instrMemBits),
    .hazardMemBits (hazardMemBits),
    .sel_hazard    (sel_hazard),
    .but_load      (but_load),
    .but_next      (but_next),
    .out_val       (out_val),
    .byte_idx      (byte_idx),
    .out_valid     (out_valid),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_val, input logic [2:0] e_idx,
                           input logic e_valid, input logic e_done);
    $display("step %s: out_val=%02h byte_idx=%0d out_valid=%0b done=%0b",
             tag, out_val, byte_idx, out_valid, done);
    check({tag, ".out_val"},   64'(out_val),   64'(e_val));
    check({tag, ".byte_idx"},  64'(byte_idx),  64'(e_idx));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
    check({tag, ".done"},      64'(done),      64'(e_done));
  endtask

  task automatic toggle_next(input int spacing);
    but_next = ~but_next;
    wait_n(spacing);
  endtask

  initial begin
    rst           = 1'b1;
    but_load      = 1'b0;
    but_next      = 1'b0;
    instrMemBits  = 64'h0;
    hazardMemBits = 64'h0;
    sel_hazard    = 1'b0;
    wait_n(3);
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    wait_n(10);
    check_out("idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Full readout of the instruction image, slow toggles.
    instrMemBits = 64'hCADC599E00000000;
    sel_hazard   = 1'b0;
    but_load     = 1'b1;
    wait_n(7);
    check_out("t1.load", exp1[0], 3'd0, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      toggle_next(1000);
      check_out($sformatf("t1.b%0d", k), exp1[k], 3'(k), 1'b1, 1'b0);
    end
`ifdef READOUT_CHECKSUM_EN
    toggle_next(1000);
    check_out("t6.csum", 8'hD1, 3'd7, 1'b1, 1'b0);
`endif
    toggle_next(1000);
    check_out("t1.done", 8'h00, 3'd7, 1'b0, 1'b1);
    toggle_next(20);
    check_out("t1.done_hold", 8'h00, 3'd7, 1'b0, 1'b1);

    // Debounce: a short pulse is rejected, a held change steps once at 7 cycles.
    but_load = 1'b0;
    wait_n(10);
    but_load = 1'b1;
    wait_n(10);
    check_out("t2.reload", 8'hCA, 3'd0, 1'b1, 1'b0);
    but_next = ~but_next;
    wait_n(3);
    but_next = ~but_next;
    wait_n(15);
    check_out("t2.bounce", 8'hCA, 3'd0, 1'b1, 1'b0);
    but_next = ~but_next;
    wait_n(6);
    check_out("t2.before", 8'hCA, 3'd0, 1'b1, 1'b0);
    wait_n(1);
    check_out("t2.step", 8'hDC, 3'd1, 1'b1, 1'b0);
    wait_n(20);
    check_out("t2.once", 8'hDC, 3'd1, 1'b1, 1'b0);

    // Shadow isolation: image inputs cleared right after the load.
    but_load = 1'b0;
    wait_n(10);
    hazardMemBits = 64'h0102030405060708;
    sel_hazard    = 1'b1;
    but_load      = 1'b1;
    wait_n(7);
    instrMemBits  = 64'h0;
    hazardMemBits = 64'h0;
    sel_hazard    = 1'b0;
    check_out("t3.b0", exp3[0], 3'd0, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      toggle_next(15);
      check_out($sformatf("t3.b%0d", k), exp3[k], 3'(k), 1'b1, 1'b0);
    end

    // Coincident load and next at byte 3: load wins.
    but_load = 1'b0;
    wait_n(10);
    hazardMemBits = 64'h1112131415161718;
    sel_hazard    = 1'b1;
    but_load      = 1'b1;
    wait_n(10);
    check_out("t4.load", 8'h11, 3'd0, 1'b1, 1'b0);
    but_load = 1'b0;
    wait_n(10);
    for (int k = 0; k < 3; k++) toggle_next(15);
    check_out("t4.b3", 8'h14, 3'd3, 1'b1, 1'b0);
    hazardMemBits = 64'hA1A2A3A4A5A6A7A8;
    but_load      = 1'b1;
    but_next      = ~but_next;
    wait_n(7);
    check_out("t4.both", 8'hA1, 3'd0, 1'b1, 1'b0);
    wait_n(20);
    check_out("t4.dropped", 8'hA1, 3'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-readout, then next ignored until a load.
    but_load = 1'b0;
    wait_n(10);
    for (int k = 0; k < 5; k++) toggle_next(15);
    check_out("t5.b5", 8'hA6, 3'd5, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_out("t5.rst", 8'h00, 3'd0, 1'b0, 1'b0);
    wait_n(2);
    rst = 1'b0;
    wait_n(10);
    toggle_next(15);
    toggle_next(15);
    check_out("t5.ignored", 8'h00, 3'd0, 1'b0, 1'b0);
    but_load = 1'b1;
    wait_n(7);
    check_out("t5.reload", 8'hA1, 3'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
